multibank_buffer: RTL

Single-clock, parametrised N-bank ("ping-pong-…") sample buffer between the ADC capture path and the USB/GPIF transfer logic. Whole banks fill in strict rotation and are offered to the reader only once complete. Overruns are flagged and counted rather than silently corrupting a bank being read. Generalises the two-bank scheme to arbitrary width, depth and bank count, with per-cycle read strobing and registered read data.

---
 rtl/multibank_buffer_pkg.sv | 14 +
 rtl/multibank_buffer_if.sv | 36 +++
 rtl/multibank_buffer_sdp_ram.sv | 28 ++
 rtl/multibank_buffer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/multibank_buffer_pkg.sv
// Shared types and defaults for the multi-bank ADC sample buffer.
package multibank_buffer_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 10;
   localparam int DEFAULT_BANK_DEPTH   = 8192;
   localparam int DEFAULT_BANK_COUNT   = 2;
   localparam int OVERFLOW_COUNT_WIDTH = 16;

   typedef enum logic [0:0] {
      WRITER_FILL = 1'b0,
      WRITER_DROP = 1'b1
   } writerState_t;

endpackage

// File: rtl/multibank_buffer_if.sv
// Capture/transfer bus of the multi-bank buffer; master is the producer/consumer side.
interface multibank_buffer_if
   import multibank_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BANK_COUNT = DEFAULT_BANK_COUNT
);
   localparam int FULL_WIDTH = $clog2(BANK_COUNT + 1);

   // Strobes carry no backpressure: isWriting offers one word per cycle (taken in FILL,
   // dropped in DROP); isReading takes one word per cycle only while dataAvailable=1,
   // and that word appears on dataOut with dataValid=1 on the following cycle.
   logic                                isWriting;
   logic [DATA_WIDTH-1:0]               dataIn;
   logic                                isReading;
   logic [DATA_WIDTH-1:0]               dataOut;
   logic                                dataValid;
   logic                                dataAvailable;
   logic                                bufferOverflow;
   logic [FULL_WIDTH-1:0]               fullBanks;
   logic [OVERFLOW_COUNT_WIDTH-1:0]     overflowCount;
   writerState_t                        writerState;

   modport master (
      output isWriting, dataIn, isReading,
      input  dataOut, dataValid, dataAvailable, bufferOverflow, fullBanks, overflowCount,
             writerState
   );

   modport slave (
      input  isWriting, dataIn, isReading,
      output dataOut, dataValid, dataAvailable, bufferOverflow, fullBanks, overflowCount,
             writerState
   );

endinterface

// File: rtl/multibank_buffer_sdp_ram.sv
// Single-clock simple dual-port RAM with a registered, resettable read port.
module multibank_buffer_sdp_ram #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  writeEnable,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  readEnable,
   input  logic [ADDR_WIDTH-1:0] readAddr,
   output logic [DATA_WIDTH-1:0] readData
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (writeEnable) mem[writeAddr] <= writeData;
   end

   // Only the output register is reset; array contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (reset)           readData <= '0;
      else if (readEnable) readData <= mem[readAddr];
   end

endmodule

// File: rtl/multibank_buffer.sv
// N-bank rotating sample buffer: whole banks fill in order and are released to the reader when complete.
// Optional overrun word counter: MULTIBANK_BUFFER_OVERFLOW_COUNT_EN.
module multibank_buffer
   import multibank_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BANK_DEPTH = DEFAULT_BANK_DEPTH,
   parameter int BANK_COUNT = DEFAULT_BANK_COUNT
) (
   input  logic                 clock,
   input  logic                 reset,
   multibank_buffer_if.slave    bus
);
   localparam int ADDR_W = $clog2(BANK_DEPTH);
   localparam int BANK_W = $clog2(BANK_COUNT);
   localparam int FULL_W = $clog2(BANK_COUNT + 1);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] DROP = 1'b1;

   logic [0:0]            writerState, writerStateNext;
   logic [BANK_W-1:0]     writeBank, readBank, nextWriteBank, nextReadBank;
   logic [ADDR_W-1:0]     writeAddr, readAddr;
   logic [BANK_COUNT-1:0] bankFull, bankFullNext;
   logic                  readAccept, readLast, writeAccept, writeLast, setOverflow;
   logic                  bufferOverflow, dataValid;
   logic [FULL_W-1:0]     fullCount;

   assign readAccept    = bus.isReading && bankFull[readBank];
   assign readLast      = readAccept && (readAddr == ADDR_W'(BANK_DEPTH - 1));
   assign writeAccept   = bus.isWriting && (writerState == FILL);
   assign writeLast     = writeAccept && (writeAddr == ADDR_W'(BANK_DEPTH - 1));
   assign nextWriteBank = (writeBank == BANK_W'(BANK_COUNT - 1)) ? '0 : writeBank + BANK_W'(1);
   assign nextReadBank  = (readBank == BANK_W'(BANK_COUNT - 1)) ? '0 : readBank + BANK_W'(1);

   // Reader release is applied before the writer looks at its next bank.
   always_comb begin
      bankFullNext = bankFull;
      if (readLast)  bankFullNext[readBank]  = 1'b0;
      if (writeLast) bankFullNext[writeBank] = 1'b1;
      writerStateNext = writerState;
      setOverflow     = 1'b0;
      case (writerState)
         FILL: if (writeLast && bankFullNext[nextWriteBank]) begin
            writerStateNext = DROP;
            setOverflow     = 1'b1;
         end
         DROP: if (!bankFullNext[writeBank]) writerStateNext = FILL;
         default: writerStateNext = FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         writerState    <= FILL;
         writeBank      <= '0;
         writeAddr      <= '0;
         readBank       <= '0;
         readAddr       <= '0;
         bankFull       <= '0;
         bufferOverflow <= 1'b0;
         dataValid      <= 1'b0;
      end else begin
         writerState <= writerStateNext;
         bankFull    <= bankFullNext;
         dataValid   <= readAccept;
         if (writeAccept) begin
            writeAddr <= writeLast ? '0 : writeAddr + ADDR_W'(1);
            if (writeLast) writeBank <= nextWriteBank;
         end
         if (readAccept) begin
            readAddr <= readLast ? '0 : readAddr + ADDR_W'(1);
            if (readLast) readBank <= nextReadBank;
         end
         if (!bus.isWriting)  bufferOverflow <= 1'b0;
         else if (setOverflow) bufferOverflow <= 1'b1;
      end
   end

   always_comb begin
      fullCount = '0;
      for (int i = 0; i < BANK_COUNT; i++) fullCount = fullCount + FULL_W'(bankFull[i]);
   end

`ifdef MULTIBANK_BUFFER_OVERFLOW_COUNT_EN
   logic [OVERFLOW_COUNT_WIDTH-1:0] overflowCount;
   logic                            dropWord;

   assign dropWord = bus.isWriting && (writerState == DROP);

   always_ff @(posedge clock) begin
      if (reset)                               overflowCount <= '0;
      else if (dropWord && (overflowCount != '1)) overflowCount <= overflowCount + OVERFLOW_COUNT_WIDTH'(1);
   end
   assign bus.overflowCount = overflowCount;
`else
   assign bus.overflowCount = '0;
`endif

   multibank_buffer_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_COUNT * BANK_DEPTH),
      .ADDR_WIDTH (BANK_W + ADDR_W)
   ) ram (
      .clock       (clock),
      .reset       (reset),
      .writeEnable (writeAccept),
      .writeAddr   ({writeBank, writeAddr}),
      .writeData   (bus.dataIn),
      .readEnable  (readAccept),
      .readAddr    ({readBank, readAddr}),
      .readData    (bus.dataOut)
   );

   assign bus.dataValid      = dataValid;
   assign bus.dataAvailable  = bankFull[readBank];
   assign bus.bufferOverflow = bufferOverflow;
   assign bus.fullBanks      = fullCount;
   assign bus.writerState    = writerState_t'(writerState);

endmodule
